// File: rtl/storage_pkg.sv
// Shared definitions for the storage arbiter: FSM state encoding, address field
// positions and a block range check.
//
// Optional feature macro used by files that import this package: STORAGE_ARB_ERR_EN.

package storage_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StAck   = 2'd3
    } state_e;

    // Word address is adr[WordAdrMsb:WordAdrLsb]; block index starts at BlkIdxLsb.
    localparam int unsigned WordAdrLsb = 2;
    localparam int unsigned WordAdrMsb = 9;
    localparam int unsigned BlkIdxLsb  = 10;
    localparam int unsigned WordAdrW   = WordAdrMsb - WordAdrLsb + 1;

    // The whole of adr[31:BlkIdxLsb] is compared, so addresses above the last
    // block never alias back onto a real block.
    function automatic logic blk_in_range(input logic [31:0] adr, input int unsigned blocks);
        logic [31:0] w_hi;
        w_hi = adr >> BlkIdxLsb;
        return (w_hi < blocks);
    endfunction

endpackage

// File: rtl/storage_arbiter_if.sv
// Bus bundle between two Wishbone masters, the storage arbiter and the SRAM
// management port.
//
//   m0_* / m1_*   : Wishbone controls, address, data, ack and read data per master
//   mgmt_*        : active-low block enables / write enables, byte mask, word
//                   address, write data and per-block read data
//   arb_busy/owner: arbiter status
//
// Modports: slave = arbiter side, master = requesters/SRAM side.
// With STORAGE_ARB_ERR_EN defined, m0_err_o / m1_err_o are added.

interface storage_arbiter_if #(
    parameter int unsigned RAM_BLOCKS = 2
) ();

    logic                      m0_cyc_i;
    logic                      m0_stb_i;
    logic                      m0_we_i;
    logic [3:0]                m0_sel_i;
    logic [31:0]               m0_adr_i;
    logic [31:0]               m0_dat_i;
    logic                      m0_ack_o;
    logic [31:0]               m0_dat_o;

    logic                      m1_cyc_i;
    logic                      m1_stb_i;
    logic                      m1_we_i;
    logic [3:0]                m1_sel_i;
    logic [31:0]               m1_adr_i;
    logic [31:0]               m1_dat_i;
    logic                      m1_ack_o;
    logic [31:0]               m1_dat_o;

`ifdef STORAGE_ARB_ERR_EN
    logic                      m0_err_o;
    logic                      m1_err_o;
`endif

    logic [RAM_BLOCKS-1:0]     mgmt_ena;
    logic [RAM_BLOCKS-1:0]     mgmt_wen;
    logic [RAM_BLOCKS*4-1:0]   mgmt_wen_mask;
    logic [7:0]                mgmt_addr;
    logic [31:0]               mgmt_wdata;
    logic [RAM_BLOCKS*32-1:0]  mgmt_rdata;

    logic                      arb_busy;
    logic                      arb_owner;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_dat_o,
`ifdef STORAGE_ARB_ERR_EN
        output m0_err_o, m1_err_o,
`endif
        output mgmt_ena, mgmt_wen, mgmt_wen_mask, mgmt_addr, mgmt_wdata,
        input  mgmt_rdata,
        output arb_busy, arb_owner
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_dat_o,
`ifdef STORAGE_ARB_ERR_EN
        input  m0_err_o, m1_err_o,
`endif
        input  mgmt_ena, mgmt_wen, mgmt_wen_mask, mgmt_addr, mgmt_wdata,
        output mgmt_rdata,
        input  arb_busy, arb_owner
    );

endinterface

// File: rtl/storage_rr_arb.sv
// Two-input round-robin picker (purely combinational).
//
//   i_req[1:0]  : request per master
//   i_last      : master granted most recently
//   o_gnt       : index of the winning master
//   o_gnt_valid : at least one request present

module storage_rr_arb (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_gnt_valid
);

    always_comb begin
        o_gnt_valid = |i_req;
        if (&i_req) begin
            o_gnt = ~i_last;
        end else begin
            o_gnt = i_req[1];
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// Two-master arbiter and sequencer for the banked management SRAM port.
// Round-robin grant, one transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
//
// Ports:
//   clk    : core clock
//   resetn : synchronous active-low reset
//   bus    : storage_arbiter_if.slave (both Wishbone masters, SRAM port, status)
//
// Parameters: RAM_BLOCKS (block count), RD_LAT (SRAM read latency 1..3),
//             BLK_W (block index width, clog2(RAM_BLOCKS), min 1).
// Optional:   STORAGE_ARB_ERR_EN turns out-of-range accesses into err_o
//             responses instead of a zero-data ack.

module storage_arbiter
    import storage_pkg::*;
#(
    parameter int unsigned RAM_BLOCKS = 2,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned BLK_W      = 1
) (
    input  logic                clk,
    input  logic                resetn,
    storage_arbiter_if.slave    bus
);

    localparam logic [1:0] WaitLoad = 2'(RD_LAT - 1);

    state_e                   r_state;
    state_e                   w_state_next;

    logic [1:0]               r_cnt;
    logic                     r_gnt;
    logic                     r_last;
    logic                     r_we;
    logic                     r_oor;
    logic [BLK_W-1:0]         r_blk;
    logic [RAM_BLOCKS-1:0]    r_ena;
    logic [RAM_BLOCKS-1:0]    r_wen;
    logic [RAM_BLOCKS*4-1:0]  r_mask;
    logic [WordAdrW-1:0]      r_addr;
    logic [31:0]              r_wdata;
    logic [31:0]              r_dat0;
    logic [31:0]              r_dat1;

    logic [1:0]               w_req;
    logic                     w_gnt;
    logic                     w_gnt_valid;
    logic                     w_we;
    logic [3:0]               w_sel;
    logic [31:0]              w_adr;
    logic [31:0]              w_wdat;
    logic                     w_in_range;
    logic [BLK_W-1:0]         w_blk;
    logic [RAM_BLOCKS-1:0]    w_blk_oh;
    logic [RAM_BLOCKS*4-1:0]  w_mask;
    logic [31:0]              w_rd_word;
    logic                     w_resp_ok;
    logic                     w_resp_err;

    assign w_req[0] = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_req[1] = bus.m1_cyc_i & bus.m1_stb_i;

    storage_rr_arb u_rr_arb (
        .i_req       (w_req),
        .i_last      (r_last),
        .o_gnt       (w_gnt),
        .o_gnt_valid (w_gnt_valid)
    );

    // Controls of the master that would be granted this cycle.
    always_comb begin
        if (w_gnt) begin
            w_we   = bus.m1_we_i;
            w_sel  = bus.m1_sel_i;
            w_adr  = bus.m1_adr_i;
            w_wdat = bus.m1_dat_i;
        end else begin
            w_we   = bus.m0_we_i;
            w_sel  = bus.m0_sel_i;
            w_adr  = bus.m0_adr_i;
            w_wdat = bus.m0_dat_i;
        end
    end

    assign w_in_range = blk_in_range(w_adr, RAM_BLOCKS);
    assign w_blk      = w_adr[BlkIdxLsb +: BLK_W];

    // One-hot block select; empty for out-of-range addresses.
    always_comb begin
        w_blk_oh = '0;
        w_mask   = '0;
        for (int i = 0; i < int'(RAM_BLOCKS); i++) begin
            if (w_in_range && (w_blk == BLK_W'(i))) begin
                w_blk_oh[i]      = 1'b1;
                w_mask[i*4 +: 4] = w_sel;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < int'(RAM_BLOCKS); i++) begin
            if (r_blk == BLK_W'(i)) begin
                w_rd_word = bus.mgmt_rdata[i*32 +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                // Out-of-range reads have nothing to wait for.
                if (r_we || r_oor) begin
                    w_state_next = StAck;
                end else begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt == 2'd0) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_blk   <= '0;
            r_ena   <= '1;
            r_wen   <= '1;
            r_mask  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dat0  <= '0;
            r_dat1  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_gnt_valid) begin
                        r_gnt   <= w_gnt;
                        r_we    <= w_we;
                        r_oor   <= ~w_in_range;
                        r_blk   <= w_blk;
                        r_ena   <= ~w_blk_oh;
                        r_wen   <= w_we ? ~w_blk_oh : '1;
                        r_mask  <= w_mask;
                        r_addr  <= w_adr[WordAdrMsb:WordAdrLsb];
                        r_wdata <= w_wdat;
                        r_cnt   <= WaitLoad;
                    end
                end
                StIssue: begin
                    r_ena   <= '1;
                    r_wen   <= '1;
                    r_mask  <= '0;
                    r_addr  <= '0;
                    r_wdata <= '0;
`ifndef STORAGE_ARB_ERR_EN
                    // Out-of-range accesses return zero data.
                    if (r_oor) begin
                        if (r_gnt) begin
                            r_dat1 <= '0;
                        end else begin
                            r_dat0 <= '0;
                        end
                    end
`endif
                end
                StWait: begin
                    if (r_cnt == 2'd0) begin
                        if (r_gnt) begin
                            r_dat1 <= w_rd_word;
                        end else begin
                            r_dat0 <= w_rd_word;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                StAck: begin
                    r_last <= r_gnt;
                end
                default: begin
                end
            endcase
        end
    end

    // A master that dropped its request before ACK gets nothing back.
    always_comb begin
        w_resp_ok  = 1'b0;
        w_resp_err = 1'b0;
        if (r_state == StAck && w_req[r_gnt]) begin
`ifdef STORAGE_ARB_ERR_EN
            w_resp_ok  = ~r_oor;
            w_resp_err = r_oor;
`else
            w_resp_ok  = 1'b1;
`endif
        end
    end

    assign bus.m0_ack_o = w_resp_ok & ~r_gnt;
    assign bus.m1_ack_o = w_resp_ok & r_gnt;
    assign bus.m0_dat_o = r_dat0;
    assign bus.m1_dat_o = r_dat1;

`ifdef STORAGE_ARB_ERR_EN
    assign bus.m0_err_o = w_resp_err & ~r_gnt;
    assign bus.m1_err_o = w_resp_err & r_gnt;
`else
    logic w_unused;
    assign w_unused = w_resp_err;
`endif

    assign bus.mgmt_ena      = r_ena;
    assign bus.mgmt_wen      = r_wen;
    assign bus.mgmt_wen_mask = r_mask;
    assign bus.mgmt_addr     = r_addr;
    assign bus.mgmt_wdata    = r_wdata;
    assign bus.arb_busy      = (r_state != StIdle);
    assign bus.arb_owner     = r_gnt;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter with a two-block SRAM model (RD_LAT=1).

module tb_storage_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    storage_arbiter_if #(.RAM_BLOCKS(2)) bus ();

    storage_arbiter #(
        .RAM_BLOCKS (2),
        .RD_LAT     (1),
        .BLK_W      (1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // SRAM model: one registered read stage, per-byte masked writes.
    logic [31:0] mem [0:1][0:255];
    logic [63:0] sram_rdata = '0;
    assign bus.mgmt_rdata = sram_rdata;

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!bus.mgmt_ena[b]) begin
                if (!bus.mgmt_wen[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.mgmt_wen_mask[b*4+k]) begin
                            mem[b][bus.mgmt_addr][k*8 +: 8] <= bus.mgmt_wdata[k*8 +: 8];
                        end
                    end
                end else begin
                    sram_rdata[b*32 +: 32] <= mem[b][bus.mgmt_addr];
                end
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mst;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [1:0]  e_ena;
        logic [1:0]  e_wen;
        logic [7:0]  e_mask;
        logic [7:0]  e_addr;
        int          e_lat;
        logic        oor;
        logic        chk_dat;
        logic [31:0] e_dat;
    } vec_t;

    function automatic vec_t mk(logic mst, logic we, logic [3:0] sel, logic [31:0] adr,
                                logic [31:0] dat, logic [1:0] e_ena, logic [1:0] e_wen,
                                logic [7:0] e_mask, logic [7:0] e_addr, int e_lat,
                                logic oor, logic chk_dat, logic [31:0] e_dat);
        vec_t v;
        v.mst = mst; v.we = we; v.sel = sel; v.adr = adr; v.dat = dat;
        v.e_ena = e_ena; v.e_wen = e_wen; v.e_mask = e_mask; v.e_addr = e_addr;
        v.e_lat = e_lat; v.oor = oor; v.chk_dat = chk_dat; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic drive(input logic m, input logic req, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (m) begin
            bus.m1_cyc_i = req; bus.m1_stb_i = req; bus.m1_we_i = we;
            bus.m1_sel_i = sel; bus.m1_adr_i = adr; bus.m1_dat_i = dat;
        end else begin
            bus.m0_cyc_i = req; bus.m0_stb_i = req; bus.m0_we_i = we;
            bus.m0_sel_i = sel; bus.m0_adr_i = adr; bus.m0_dat_i = dat;
        end
    endtask

    function automatic logic get_ack(input logic m);
        return m ? bus.m1_ack_o : bus.m0_ack_o;
    endfunction

    function automatic logic get_err(input logic m);
`ifdef STORAGE_ARB_ERR_EN
        return m ? bus.m1_err_o : bus.m0_err_o;
`else
        return m ? 1'b0 : 1'b0;
`endif
    endfunction

    function automatic logic [31:0] get_dat(input logic m);
        return m ? bus.m1_dat_o : bus.m0_dat_o;
    endfunction

    logic [31:0] prev_dat [0:1];

    task automatic check_reset_state(input string tag);
        chk({tag, " ena"},   64'(bus.mgmt_ena), 64'h3);
        chk({tag, " wen"},   64'(bus.mgmt_wen), 64'h3);
        chk({tag, " mask"},  64'(bus.mgmt_wen_mask), 64'h0);
        chk({tag, " addr"},  64'(bus.mgmt_addr), 64'h0);
        chk({tag, " wdata"}, 64'(bus.mgmt_wdata), 64'h0);
        chk({tag, " acks"},  64'({bus.m1_ack_o, bus.m0_ack_o}), 64'h0);
        chk({tag, " dat0"},  64'(bus.m0_dat_o), 64'h0);
        chk({tag, " dat1"},  64'(bus.m1_dat_o), 64'h0);
        chk({tag, " busy"},  64'(bus.arb_busy), 64'h0);
        chk({tag, " owner"}, 64'(bus.arb_owner), 64'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        int    lat;
        int    other_acks;
        logic  got;
        logic  err_mode;
        tag = $sformatf("v%0d", idx);
`ifdef STORAGE_ARB_ERR_EN
        err_mode = v.oor;
`else
        err_mode = 1'b0;
`endif
        @(posedge clk); #1;
        drive(v.mst, 1'b1, v.we, v.sel, v.adr, v.dat);
        @(posedge clk); #1;
        // ISSUE cycle
        chk({tag, " issue ena"},   64'(bus.mgmt_ena), 64'(v.e_ena));
        chk({tag, " issue wen"},   64'(bus.mgmt_wen), 64'(v.e_wen));
        chk({tag, " issue mask"},  64'(bus.mgmt_wen_mask), 64'(v.e_mask));
        chk({tag, " issue addr"},  64'(bus.mgmt_addr), 64'(v.e_addr));
        chk({tag, " issue owner"}, 64'(bus.arb_owner), 64'(v.mst));
        chk({tag, " issue busy"},  64'(bus.arb_busy), 64'h1);
        if (v.we && !v.oor) chk({tag, " issue wdata"}, 64'(bus.mgmt_wdata), 64'(v.dat));
        lat = 0;
        got = 1'b0;
        other_acks = 0;
        for (int c = 2; c <= 10 && !got; c++) begin
            @(posedge clk); #1;
            if (get_ack(!v.mst) || get_err(!v.mst)) other_acks++;
            if (get_ack(v.mst) || get_err(v.mst)) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({tag, " ack cycle"}, 64'(lat), 64'(v.e_lat));
        chk({tag, " other ack"}, 64'(other_acks), 64'h0);
        if (got) begin
            chk({tag, " ack/err"}, 64'({get_err(v.mst), get_ack(v.mst)}),
                err_mode ? 64'h2 : 64'h1);
            chk({tag, " ena idle"}, 64'(bus.mgmt_ena), 64'h3);
            if (err_mode) begin
                chk({tag, " dat held"}, 64'(get_dat(v.mst)), 64'(prev_dat[v.mst]));
            end else if (v.chk_dat) begin
                chk({tag, " dat"}, 64'(get_dat(v.mst)), 64'(v.e_dat));
                prev_dat[v.mst] = v.e_dat;
            end
        end
        @(posedge clk); #1;
        drive(v.mst, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    vec_t vecs [0:10];

    initial begin
        int   order [0:3];
        int   n_ack;
        int   both;
        logic m_ack;

        for (int i = 0; i < 256; i++) begin
            mem[0][i] = 32'hB0B0_0000;
            mem[1][i] = 32'hB1B1_0000;
        end
        prev_dat[0] = '0;
        prev_dat[1] = '0;

        //           mst we  sel    adr           dat           ena    wen    mask   addr lat oor chkd exp_dat
        vecs[0]  = mk(0, 1, 4'h3, 32'h0000_0014, 32'hA5A5_1234, 2'b10, 2'b10, 8'h03, 8'h05, 2, 0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 4'hF, 32'h0000_0014, 32'h0,         2'b10, 2'b11, 8'h0F, 8'h05, 3, 0, 1, 32'hB0B0_1234);
        vecs[2]  = mk(1, 0, 4'hF, 32'h0000_0400, 32'h0,         2'b01, 2'b11, 8'hF0, 8'h00, 3, 0, 1, 32'hB1B1_0000);
        vecs[3]  = mk(1, 1, 4'hC, 32'h0000_0404, 32'h5A5A_F00D, 2'b01, 2'b01, 8'hC0, 8'h01, 2, 0, 0, 32'h0);
        vecs[4]  = mk(1, 0, 4'hF, 32'h0000_0404, 32'h0,         2'b01, 2'b11, 8'hF0, 8'h01, 3, 0, 1, 32'h5A5A_0000);
        vecs[5]  = mk(0, 1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 2'b10, 2'b10, 8'h00, 8'h05, 2, 0, 0, 32'h0);
        vecs[6]  = mk(0, 0, 4'hF, 32'h0000_0014, 32'h0,         2'b10, 2'b11, 8'h0F, 8'h05, 3, 0, 1, 32'hB0B0_1234);
        vecs[7]  = mk(0, 0, 4'hF, 32'h0000_0800, 32'h0,         2'b11, 2'b11, 8'h00, 8'h00, 2, 1, 1, 32'h0);
        vecs[8]  = mk(1, 1, 4'hF, 32'h0000_03FC, 32'h1234_5678, 2'b10, 2'b10, 8'h0F, 8'hFF, 2, 0, 0, 32'h0);
        vecs[9]  = mk(0, 0, 4'hF, 32'h0000_03FC, 32'h0,         2'b10, 2'b11, 8'h0F, 8'hFF, 3, 0, 1, 32'h1234_5678);
        vecs[10] = mk(1, 1, 4'hF, 32'h0000_0C04, 32'hDEAD_BEEF, 2'b11, 2'b11, 8'h00, 8'h01, 2, 1, 1, 32'h0);

        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        resetn = 1'b1;

        for (int i = 0; i <= 10; i++) run_vec(i, vecs[i]);

        // Both masters request continuously from reset: expect 0,1,0,1.
        @(posedge clk); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        prev_dat[0] = '0;
        prev_dat[1] = '0;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h0000_00A0);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0420, 32'h0000_00A1);
        n_ack = 0;
        both = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (bus.m0_ack_o && bus.m1_ack_o) both++;
            m_ack = bus.m0_ack_o | bus.m1_ack_o;
            if (m_ack && n_ack < 4) begin
                order[n_ack] = bus.m1_ack_o ? 1 : 0;
                n_ack++;
            end
        end
        chk("rr ack count", 64'(n_ack), 64'd4);
        chk("rr dual ack", 64'(both), 64'd0);
        if (n_ack == 4) begin
            chk("rr grant 0", 64'(order[0]), 64'd0);
            chk("rr grant 1", 64'(order[1]), 64'd1);
            chk("rr grant 2", 64'(order[2]), 64'd0);
            chk("rr grant 3", 64'(order[3]), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        chk("rr mem m0", 64'(mem[0][8]), 64'h0000_00A0);
        chk("rr mem m1", 64'(mem[1][8]), 64'h0000_00A1);

        // Reset asserted during WAIT of an M0 read: dropped, no ack.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
        @(posedge clk); #1;                   // ISSUE
        @(posedge clk); #1;                   // WAIT
        chk("rst-wait busy", 64'(bus.arb_busy), 64'h1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_state("rst-wait");
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        prev_dat[0] = '0;
        prev_dat[1] = '0;
        run_vec(11, mk(1, 1, 4'h1, 32'h0000_0408, 32'h0000_0077,
                       2'b01, 2'b01, 8'h10, 8'h02, 2, 0, 0, 32'h0));
        run_vec(12, vecs[6]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
